// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the pipe_reg register pipeline.
package pipe_reg_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 3;
   localparam int MAX_WIDTH = 64;
   localparam int MAX_DEPTH = 16;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: a valid bit and a data register with a load enable.
// Data only loads when the incoming valid is set, so bubbles keep old data.
module pipe_reg_stage
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             load_en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_r;
   logic [WIDTH-1:0] data_r;

   // Valid bit: cleared by reset or flush, otherwise follows upstream when enabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (load_en) begin
         valid_r <= in_valid;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Data register: holds across flush and bubbles, loads only real payload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r <= RST_VAL;
      end else if (!flush && load_en && in_valid) begin
         data_r <= in_data;
      end else begin
         data_r <= data_r;
      end
   end

   assign valid = valid_r;
   assign data  = data_r;

endmodule

// File: rtl/pipe_reg.sv
// Multi-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg
   import pipe_reg_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter int               DEPTH   = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush_i,
   input  logic                          in_valid_i,
   input  logic [WIDTH-1:0]              in_data_i,
   output logic                          in_ready_o,
   output logic                          out_valid_o,
   output logic [WIDTH-1:0]              out_data_o,
   input  logic                          out_ready_i,
   output logic [cnt_width(DEPTH)-1:0]   count_o
);

   localparam int CW = cnt_width(DEPTH);

   // Parameter range guards, evaluated at elaboration.
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("pipe_reg: WIDTH must be in 1..64");
   end
   if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("pipe_reg: DEPTH must be in 1..16");
   end

   logic [DEPTH-1:0] valid_s;
   logic [DEPTH-1:0] rdy_s;
   logic [WIDTH-1:0] data_s [DEPTH];
   logic             in_hs_s;
   logic             out_hs_s;
   logic [CW-1:0]    count_r;

   // Readiness ripples from the output back to the input: a stage can take
   // new content if it is empty or the stage after it is moving.
   always_comb begin
      rdy_s = {DEPTH{1'b0}};
      rdy_s[DEPTH-1] = !valid_s[DEPTH-1] | out_ready_i;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         rdy_s[k] = !valid_s[k] | rdy_s[k+1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             prev_valid_s;
      logic [WIDTH-1:0] prev_data_s;

      if (k == 0) begin : g_head
         assign prev_valid_s = in_valid_i;
         assign prev_data_s  = in_data_i;
      end else begin : g_body
         assign prev_valid_s = valid_s[k-1];
         assign prev_data_s  = data_s[k-1];
      end

      pipe_reg_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk      (clk),
         .reset_n  (reset_n),
         .flush    (flush_i),
         .load_en  (rdy_s[k]),
         .in_valid (prev_valid_s),
         .in_data  (prev_data_s),
         .valid    (valid_s[k]),
         .data     (data_s[k])
      );
   end

   assign in_ready_o  = rdy_s[0] & !flush_i;
   assign out_valid_o = valid_s[DEPTH-1] & !flush_i;
   assign out_data_o  = data_s[DEPTH-1];

   assign in_hs_s  = in_valid_i & in_ready_o;
   assign out_hs_s = out_valid_o & out_ready_i;

   // Occupancy: +1 on input-only, -1 on output-only, cleared on flush; saturates at both ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {CW{1'b0}};
      end else if (flush_i) begin
         count_r <= {CW{1'b0}};
      end else if (in_hs_s && !out_hs_s && (count_r != CW'(DEPTH))) begin
         count_r <= count_r + CW'(1);
      end else if (out_hs_s && !in_hs_s && (count_r != {CW{1'b0}})) begin
         count_r <= count_r - CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count_o = count_r;

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios on a DEPTH=3 instance
// and a random valid/ready/flush run on DEPTH 3, 1, 4 and 16 instances.
module tb_pipe_reg;

   localparam int NI = 4;

   function automatic int depth_of(input int g);
      case (g)
         0:       return 3;
         1:       return 1;
         2:       return 4;
         default: return 16;
      endcase
   endfunction

   logic       clk = 1'b0;
   logic       reset_n;
   logic       flush;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] in_data;

   logic       ir  [NI];
   logic       ov  [NI];
   logic [7:0] od  [NI];
   logic [4:0] cnt [NI];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q [NI][$];
   int         emitted [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = depth_of(g);
      logic                     ir_w;
      logic                     ov_w;
      logic [7:0]               od_w;
      logic [$clog2(D+1)-1:0]   cnt_w;

      pipe_reg #(
         .WIDTH   (8),
         .DEPTH   (D),
         .RST_VAL ((g == 0) ? 8'hA5 : 8'h00)
      ) u_dut (
         .clk         (clk),
         .reset_n     (reset_n),
         .flush_i     (flush),
         .in_valid_i  (in_valid),
         .in_data_i   (in_data),
         .in_ready_o  (ir_w),
         .out_valid_o (ov_w),
         .out_data_o  (od_w),
         .out_ready_i (out_ready),
         .count_o     (cnt_w)
      );

      assign ir[g]  = ir_w;
      assign ov[g]  = ov_w;
      assign od[g]  = od_w;
      assign cnt[g] = 5'(cnt_w);
   end

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running sim, required finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      for (int g = 0; g < NI; g++) begin
         n_checks++;
         if (ov[g] !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid inst%0d: got %b required 0", g, ov[g]);
         end
         n_checks++;
         if (ir[g] !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready inst%0d: got %b required 1", g, ir[g]);
         end
         n_checks++;
         if (cnt[g] !== 5'd0) begin
            n_fail++; $display("FAIL reset_count inst%0d: got %0d required 0", g, cnt[g]);
         end
      end
      n_checks++;
      if (od[0] !== 8'hA5) begin
         n_fail++; $display("FAIL reset_data: got %h required a5", od[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_latency();
      int peak;
      int exp_cnt;
      int n_in;
      int n_out;
      logic [7:0] exp_od;
      do_reset();
      out_ready = 1'b1;
      peak = 0;
      for (int c = 0; c < 7; c++) begin
         in_valid = (c < 3);
         in_data  = (c < 3) ? 8'((c + 1) * 17) : 8'h00;
         #1;
         n_in    = (c < 3) ? c : 3;
         n_out   = (c <= 3) ? 0 : ((c - 3 > 3) ? 3 : c - 3);
         exp_cnt = n_in - n_out;
         exp_od  = 8'((c - 2) * 17);
         n_checks++;
         if (ov[0] !== ((c >= 3) && (c <= 5))) begin
            n_fail++; $display("FAIL latency_valid cycle%0d: got %b", c, ov[0]);
         end
         if (c >= 3 && c <= 5) begin
            n_checks++;
            if (od[0] !== exp_od) begin
               n_fail++; $display("FAIL latency_data cycle%0d: got %h required %h", c, od[0], exp_od);
            end
         end
         n_checks++;
         if (cnt[0] !== 5'(exp_cnt)) begin
            n_fail++; $display("FAIL latency_count cycle%0d: got %0d required %0d", c, cnt[0], exp_cnt);
         end
         if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
         @(negedge clk);
      end
      n_checks++;
      if (peak !== 3) begin
         n_fail++; $display("FAIL latency_peak: got %0d required 3", peak);
      end
   endtask

   task automatic test_backpressure();
      int got;
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h40 + c);
         #1;
         n_checks++;
         if (ir[0] !== (c < 3)) begin
            n_fail++; $display("FAIL bp_in_ready cycle%0d: got %b required %b", c, ir[0], (c < 3));
         end
         if (c == 3) begin
            n_checks++;
            if (cnt[0] !== 5'd3) begin
               n_fail++; $display("FAIL bp_count_full: got %0d required 3", cnt[0]);
            end
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (ov[0]) begin
            n_checks++;
            if (got >= 3 || od[0] !== 8'(8'h40 + got)) begin
               n_fail++; $display("FAIL bp_drain_order item%0d: got %h required %h", got, od[0], 8'(8'h40 + got));
            end
            got++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (got !== 3) begin
         n_fail++; $display("FAIL bp_drain_total: got %0d required 3", got);
      end
      #1;
      n_checks++;
      if (cnt[0] !== 5'd0) begin
         n_fail++; $display("FAIL bp_count_empty: got %0d required 0", cnt[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n_in;
      int n_out;
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h80 + c);
         @(negedge clk);
      end
      n_in  = 0;
      n_out = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h83 + i);
         #1;
         n_checks++;
         if (od[0] !== 8'(8'h80 + i) || ov[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_out item%0d: got %b/%h required 1/%h", i, ov[0], od[0], 8'(8'h80 + i));
         end
         n_checks++;
         if (cnt[0] !== 5'd3) begin
            n_fail++; $display("FAIL b2b_count cycle%0d: got %0d required 3", i, cnt[0]);
         end
         if (in_valid && ir[0]) n_in++;
         if (ov[0] && out_ready) n_out++;
         @(negedge clk);
      end
      n_checks++;
      if (n_in !== 10 || n_out !== 10) begin
         n_fail++; $display("FAIL b2b_handshakes: got %0d in %0d out required 10 in 10 out", n_in, n_out);
      end
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (cnt[0] !== 5'd3) begin
         n_fail++; $display("FAIL b2b_count_after: got %0d required 3", cnt[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h51 + c);
         @(negedge clk);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      #1;
      n_checks++;
      if (cnt[0] !== 5'd2 || ir[0] !== 1'b0) begin
         n_fail++; $display("FAIL flush_during: got count %0d ready %b required 2 0", cnt[0], ir[0]);
      end
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (cnt[0] !== 5'd0 || ov[0] !== 1'b0) begin
         n_fail++; $display("FAIL flush_after: got count %0d valid %b required 0 0", cnt[0], ov[0]);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL flush_ghost cycle%0d: got valid %b data %h required 0", c, ov[0], od[0]);
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h61 + c);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      flush     = 1'b1;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (ov[0] !== 1'b0) begin
         n_fail++; $display("FAIL flush_full_gate: got valid %b required 0", ov[0]);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_checks++;
      if (ov[0] !== 1'b0 || cnt[0] !== 5'd0) begin
         n_fail++; $display("FAIL flush_full_after: got valid %b count %0d required 0 0", ov[0], cnt[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h11 * (c + 1));
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (ov[0] !== 1'b1 || od[0] !== 8'h11) begin
         n_fail++; $display("FAIL areset_pre: got %b/%h required 1/11", ov[0], od[0]);
      end
      reset_n   = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (ov[0] !== 1'b0 || od[0] !== 8'hA5 || cnt[0] !== 5'd0) begin
         n_fail++; $display("FAIL areset_now: got %b/%h/%0d required 0/a5/0", ov[0], od[0], cnt[0]);
      end
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || cnt[0] !== 5'd0) begin
         n_fail++; $display("FAIL areset_after: got valid %b ready %b count %0d required 0 1 0", ov[0], ir[0], cnt[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int   seq;
      int   cycles;
      int   drain_cycles;
      int   min_emit;
      logic drain;
      logic exp_ir;
      do_reset();
      for (int g = 0; g < NI; g++) begin
         q[g].delete();
         emitted[g] = 0;
      end
      seq = 0;
      cycles = 0;
      drain = 1'b0;
      drain_cycles = 0;
      while (cycles < 25000) begin
         min_emit = emitted[0];
         for (int g = 1; g < NI; g++) if (emitted[g] < min_emit) min_emit = emitted[g];
         if (!drain && min_emit >= 1000) drain = 1'b1;
         if (drain && drain_cycles >= 40) break;
         if (drain) begin
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            drain_cycles++;
         end else begin
            flush     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 99) < 65);
            out_ready = ($urandom_range(0, 99) < 65);
         end
         in_data = 8'(seq);
         seq++;
         #1;
         for (int g = 0; g < NI; g++) begin
            exp_ir = !flush && ((q[g].size() < depth_of(g)) || out_ready);
            n_checks++;
            if (ir[g] !== exp_ir) begin
               n_fail++; $display("FAIL rnd_in_ready inst%0d cyc%0d: got %b required %b", g, cycles, ir[g], exp_ir);
            end
            n_checks++;
            if (cnt[g] !== 5'(q[g].size())) begin
               n_fail++; $display("FAIL rnd_count inst%0d cyc%0d: got %0d required %0d", g, cycles, cnt[g], q[g].size());
            end
            if (ov[g] === 1'b1) begin
               n_checks++;
               if (flush || q[g].size() == 0 || od[g] !== q[g][0]) begin
                  n_fail++; $display("FAIL rnd_order inst%0d cyc%0d: got %h required %h (in flight %0d)", g, cycles, od[g], (q[g].size() > 0) ? q[g][0] : 8'h00, q[g].size());
               end
            end
            if (flush) begin
               q[g].delete();
            end else begin
               if (ov[g] === 1'b1 && out_ready && q[g].size() > 0) begin
                  void'(q[g].pop_front());
                  emitted[g]++;
               end
               if (in_valid && ir[g] === 1'b1) q[g].push_back(in_data);
            end
         end
         cycles++;
         @(negedge clk);
      end
      n_checks++;
      if (!drain) begin
         n_fail++; $display("FAIL rnd_budget: got min emitted %0d required 1000 within budget", min_emit);
      end
      #1;
      for (int g = 0; g < NI; g++) begin
         n_checks++;
         if (q[g].size() !== 0 || cnt[g] !== 5'd0) begin
            n_fail++; $display("FAIL rnd_drain inst%0d: got %0d left count %0d required 0 0", g, q[g].size(), cnt[g]);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
